// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Define PS2_TX_TIMEOUT_EN to add a device-clock watchdog.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYC = 5000,
   parameter int unsigned FILTER_LEN  = 8,
   parameter int unsigned TIMEOUT_CYC = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] din,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       busy,
   output logic       tx_done_tick,
   output logic       tx_err_tick
);

   // One counter serves the inhibit delay and the watchdog.
   localparam int unsigned CMAX =
      (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      RTS,
      START,
      DATA,
      STOP,
      ACK,
      WAITREL
   } state_t;

   logic                  c_s1_q;
   logic                  c_s2_q;
   logic                  d_s1_q;
   logic                  d_s2_q;
   logic [FILTER_LEN-1:0] filt_q;
   logic                  c_f_q;
   logic                  c_f_d;
   logic                  fall_q;

   state_t                state_q;
   logic [8:0]            sh_q;
   logic [3:0]            bit_q;
   logic [CW-1:0]         cnt_q;

   always_comb begin
      c_f_d = c_f_q;
      if (&filt_q) begin
         c_f_d = 1'b1;
      end else if (~|filt_q) begin
         c_f_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_s1_q <= 1'b1;
         c_s2_q <= 1'b1;
         d_s1_q <= 1'b1;
         d_s2_q <= 1'b1;
         filt_q <= '1;
         c_f_q  <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         c_s1_q <= ps2c_in;
         c_s2_q <= c_s1_q;
         d_s1_q <= ps2d_in;
         d_s2_q <= d_s1_q;
         filt_q <= {filt_q[FILTER_LEN-2:0], c_s2_q};
         c_f_q  <= c_f_d;
         fall_q <= c_f_q & ~c_f_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sh_q         <= '0;
         bit_q        <= '0;
         cnt_q        <= '0;
         ps2c_oe      <= 1'b0;
         ps2d_oe      <= 1'b0;
         busy         <= 1'b0;
         tx_done_tick <= 1'b0;
         tx_err_tick  <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         tx_err_tick  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (wr_en) begin
                  sh_q    <= {~^din, din};
                  cnt_q   <= '0;
                  ps2c_oe <= 1'b1;
                  busy    <= 1'b1;
                  state_q <= RTS;
               end
            end
            RTS: begin
               if (cnt_q == INH_LAST) begin
                  cnt_q   <= '0;
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b1;
                  state_q <= START;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            START: begin
               if (fall_q) begin
                  bit_q   <= 4'd8;
                  ps2d_oe <= ~sh_q[0];
                  state_q <= DATA;
               end
            end
            DATA: begin
               if (fall_q) begin
                  if (bit_q == 4'd0) begin
                     ps2d_oe <= 1'b0;
                     state_q <= STOP;
                  end else begin
                     // Present the bit that becomes shift[0] after this shift.
                     sh_q    <= {1'b0, sh_q[8:1]};
                     ps2d_oe <= ~sh_q[1];
                     bit_q   <= bit_q - 4'd1;
                  end
               end
            end
            STOP: begin
               if (fall_q) begin
                  state_q <= ACK;
               end
            end
            ACK: begin
               if (fall_q) begin
                  if (d_s2_q) begin
                     tx_err_tick <= 1'b1;
                     busy        <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     state_q <= WAITREL;
                  end
               end
            end
            WAITREL: begin
               if (c_f_q && d_s2_q) begin
                  tx_done_tick <= 1'b1;
                  busy         <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
`ifdef PS2_TX_TIMEOUT_EN
         // Watchdog overrides any completion in the same cycle.
         if (state_q inside {START, DATA, STOP, ACK, WAITREL}) begin
            if (fall_q) begin
               cnt_q <= '0;
            end else if (cnt_q == TO_LAST) begin
               cnt_q        <= '0;
               ps2c_oe      <= 1'b0;
               ps2d_oe      <= 1'b0;
               busy         <= 1'b0;
               tx_done_tick <= 1'b0;
               tx_err_tick  <= 1'b1;
               state_q      <= IDLE;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
`endif
      end
   end

endmodule
